// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipeline_stall_controller_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_capture_unit.sv
// Late-writeback capture select for the ID/EX source operands while EX is frozen.
module hazard_capture_unit
  import pipeline_stall_controller_pkg::*;
(
  input  logic              i_ex_stall,
  input  logic              i_wb_regwrite,
  input  logic [REG_W-1:0]  i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_result,
  input  logic [REG_W-1:0]  i_ex_rs1,
  input  logic [REG_W-1:0]  i_ex_rs2,
  output logic              o_rs1_en,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic              o_rs2_en,
  output logic [DATA_W-1:0] o_rs2_data
);

  logic w_wb_live;

  // Writeback only matters when it targets a real register and EX is held.
  always_comb begin
    w_wb_live  = i_ex_stall && i_wb_regwrite && (i_wb_rd != REG_ZERO);
    o_rs1_en   = w_wb_live && (i_wb_rd == i_ex_rs1);
    o_rs2_en   = w_wb_live && (i_wb_rd == i_ex_rs2);
    o_rs1_data = o_rs1_en ? i_wb_result : '0;
    o_rs2_data = o_rs2_en ? i_wb_result : '0;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer: load-use bubbles, redirect flushes and
// data-memory wait freezing with a sticky timeout error.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  ID_rs1,
  input  logic [REG_W-1:0]  ID_rs2,
  input  logic              ID_uses_rs1,
  input  logic              ID_uses_rs2,
  input  logic [REG_W-1:0]  ID_EX_rs1,
  input  logic [REG_W-1:0]  ID_EX_rs2,
  input  logic [REG_W-1:0]  ID_EX_rd,
  input  logic              ID_EX_memread,
  input  logic [REG_W-1:0]  MEM_WB_rd,
  input  logic              MEM_WB_regwrite,
  input  logic [DATA_W-1:0] MEM_WB_result,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              EX_redirect,
  output logic              PC_stall,
  output logic              IF_ID_stall,
  output logic              EX_stall,
  output logic              MEM_stall,
  output logic              ID_EX_bubble,
  output logic              IF_ID_flush,
  output logic              EX_hazard_rs1_data_enable,
  output logic              EX_hazard_rs2_data_enable,
  output logic [DATA_W-1:0] EX_hazard_rs1_data,
  output logic [DATA_W-1:0] EX_hazard_rs2_data,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_err;
  logic [PERF_W-1:0]  r_stall_cycles;
  logic               w_load_use;
  logic               w_freeze;
  logic               w_cnt_clr;
  logic               w_cnt_inc;

  // Load in EX feeding a source the ID instruction actually reads.
  always_comb begin
    w_load_use = ID_EX_memread && (ID_EX_rd != REG_ZERO) &&
                 ((ID_uses_rs1 && (ID_rs1 == ID_EX_rd)) ||
                  (ID_uses_rs2 && (ID_rs2 == ID_EX_rd)));
  end

  // Next state and same-cycle control; priority ERROR > memwait > redirect > load-use.
  always_comb begin
    w_next       = r_state;
    w_freeze     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (!reset) begin
      w_next   = RUN;
      w_freeze = (r_state == ERROR);
    end else begin
      unique case (r_state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            w_freeze  = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = MEM_WAIT;
          end else if (EX_redirect) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (w_load_use) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            w_freeze = 1'b1;
            if (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
              w_next = ERROR;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else begin
            w_next = RUN;
            if (EX_redirect) begin
              IF_ID_flush  = 1'b1;
              ID_EX_bubble = 1'b1;
            end
          end
        end
        ERROR: begin
          w_freeze = 1'b1;
        end
        default: begin
          w_next = RUN;
        end
      endcase
    end
    if (w_freeze) begin
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
    end
    EX_stall  = w_freeze;
    MEM_stall = w_freeze;
  end

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_err          <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr) begin
        r_wait_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if (w_next == ERROR) begin
        r_err <= 1'b1;
      end
      if (PC_stall && (r_stall_cycles != {PERF_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
    end
  end

  assign mem_timeout_err = r_err;
  assign stall_cycles    = r_stall_cycles;

  hazard_capture_unit u_capture (
    .i_ex_stall    (EX_stall),
    .i_wb_regwrite (MEM_WB_regwrite),
    .i_wb_rd       (MEM_WB_rd),
    .i_wb_result   (MEM_WB_result),
    .i_ex_rs1      (ID_EX_rs1),
    .i_ex_rs2      (ID_EX_rs2),
    .o_rs1_en      (EX_hazard_rs1_data_enable),
    .o_rs1_data    (EX_hazard_rs1_data),
    .o_rs2_en      (EX_hazard_rs2_data_enable),
    .o_rs2_data    (EX_hazard_rs2_data)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed per-cycle vectors
// push expectations, a negedge monitor pops and compares.
module tb_pipeline_stall_controller;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int unsigned TB_PERF_W  = 4;

  logic        clk = 1'b1;
  logic        reset;
  logic [4:0]  ID_rs1, ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, MEM_WB_rd;
  logic        ID_uses_rs1, ID_uses_rs2, ID_EX_memread, MEM_WB_regwrite;
  logic [31:0] MEM_WB_result;
  logic        dmem_req, dmem_ready, EX_redirect;
  logic        PC_stall, IF_ID_stall, EX_stall, MEM_stall, ID_EX_bubble, IF_ID_flush;
  logic        EX_hazard_rs1_data_enable, EX_hazard_rs2_data_enable;
  logic [31:0] EX_hazard_rs1_data, EX_hazard_rs2_data;
  logic        mem_timeout_err;
  logic [TB_PERF_W-1:0] stall_cycles;

  typedef struct {
    logic [5:0]           ctrl;  // {pc, ifid, ex, mem, bubble, flush}
    logic                 e1;
    logic [31:0]          d1;
    logic                 e2;
    logic [31:0]          d2;
    logic                 err;
    logic [TB_PERF_W-1:0] cnt;
  } exp_t;

  exp_t  q[$];
  string names[$];
  int    checks = 0;
  int    errors = 0;
  logic [TB_PERF_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .PERF_W      (TB_PERF_W)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .ID_rs1                    (ID_rs1),
    .ID_rs2                    (ID_rs2),
    .ID_uses_rs1               (ID_uses_rs1),
    .ID_uses_rs2               (ID_uses_rs2),
    .ID_EX_rs1                 (ID_EX_rs1),
    .ID_EX_rs2                 (ID_EX_rs2),
    .ID_EX_rd                  (ID_EX_rd),
    .ID_EX_memread             (ID_EX_memread),
    .MEM_WB_rd                 (MEM_WB_rd),
    .MEM_WB_regwrite           (MEM_WB_regwrite),
    .MEM_WB_result             (MEM_WB_result),
    .dmem_req                  (dmem_req),
    .dmem_ready                (dmem_ready),
    .EX_redirect               (EX_redirect),
    .PC_stall                  (PC_stall),
    .IF_ID_stall               (IF_ID_stall),
    .EX_stall                  (EX_stall),
    .MEM_stall                 (MEM_stall),
    .ID_EX_bubble              (ID_EX_bubble),
    .IF_ID_flush               (IF_ID_flush),
    .EX_hazard_rs1_data_enable (EX_hazard_rs1_data_enable),
    .EX_hazard_rs2_data_enable (EX_hazard_rs2_data_enable),
    .EX_hazard_rs1_data        (EX_hazard_rs1_data),
    .EX_hazard_rs2_data        (EX_hazard_rs2_data),
    .mem_timeout_err           (mem_timeout_err),
    .stall_cycles              (stall_cycles)
  );

  // Monitor: compare presented outputs against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [5:0] act_ctrl;
      e  = q.pop_front();
      nm = names.pop_front();
      act_ctrl = {PC_stall, IF_ID_stall, EX_stall, MEM_stall, ID_EX_bubble, IF_ID_flush};
      checks++;
      if (act_ctrl !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b", nm, act_ctrl, e.ctrl);
      end
      checks++;
      if ({EX_hazard_rs1_data_enable, EX_hazard_rs1_data, EX_hazard_rs2_data_enable, EX_hazard_rs2_data}
          !== {e.e1, e.d1, e.e2, e.d2}) begin
        errors++;
        $display("FAIL %s capture: got %b/%h %b/%h expected %b/%h %b/%h", nm,
                 EX_hazard_rs1_data_enable, EX_hazard_rs1_data,
                 EX_hazard_rs2_data_enable, EX_hazard_rs2_data, e.e1, e.d1, e.e2, e.d2);
      end
      checks++;
      if (mem_timeout_err !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b expected %b", nm, mem_timeout_err, e.err);
      end
      checks++;
      if (stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, e.cnt);
      end
    end
  end

  // Queue one cycle's expectation, advance the stall-count model, step the clock.
  task automatic cyc(input string nm, input logic [5:0] ctrl,
                     input logic e1, input logic [31:0] d1,
                     input logic e2, input logic [31:0] d2, input logic err);
    exp_t e;
    e.ctrl = ctrl; e.e1 = e1; e.d1 = d1; e.e2 = e2; e.d2 = d2;
    e.err = err; e.cnt = exp_cnt;
    q.push_back(e);
    names.push_back(nm);
    if (!reset) exp_cnt = '0;
    else if (ctrl[5] && exp_cnt != {TB_PERF_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs1 = '0; ID_rs2 = '0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
    ID_EX_rs1 = '0; ID_EX_rs2 = '0; ID_EX_rd = '0; ID_EX_memread = 0;
    MEM_WB_rd = '0; MEM_WB_regwrite = 0; MEM_WB_result = '0;
    dmem_req = 0; dmem_ready = 0; EX_redirect = 0;
  endtask

  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] LU     = 6'b110010;
  localparam logic [5:0] FREEZE = 6'b111100;
  localparam logic [5:0] FLUSH  = 6'b000011;

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    cyc("rst_hold", NONE, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc("idle", NONE, 0, 0, 0, 0, 0);

    // Load-use
    ID_EX_memread = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_uses_rs1 = 1;
    cyc("lu_rs1", LU, 0, 0, 0, 0, 0);
    ID_EX_memread = 0;
    cyc("lu_clear", NONE, 0, 0, 0, 0, 0);
    ID_EX_memread = 1; ID_EX_rd = 0; ID_rs1 = 0;
    cyc("lu_rd0", NONE, 0, 0, 0, 0, 0);
    ID_EX_rd = 5; ID_rs1 = 5; ID_uses_rs1 = 0;
    cyc("lu_nouse", NONE, 0, 0, 0, 0, 0);
    ID_uses_rs2 = 1; ID_rs2 = 5;
    cyc("lu_rs2", LU, 0, 0, 0, 0, 0);
    clear_inputs();

    // Memory wait with capture and deferred redirect
    dmem_req = 1; ID_EX_rs1 = 3; MEM_WB_rd = 3; MEM_WB_regwrite = 1; MEM_WB_result = 32'h12345678;
    cyc("mw_run_cap1", FREEZE, 1, 32'h12345678, 0, 0, 0);
    ID_EX_rs1 = 0; ID_EX_rs2 = 7; MEM_WB_rd = 7; MEM_WB_result = 32'hDEADBEEF;
    cyc("mw_cap2", FREEZE, 0, 0, 1, 32'hDEADBEEF, 0);
    MEM_WB_rd = 0; ID_EX_rs2 = 0; EX_redirect = 1;
    cyc("mw_cap_x0_redir", FREEZE, 0, 0, 0, 0, 0);
    dmem_ready = 1; ID_EX_rs1 = 9; MEM_WB_rd = 9;
    cyc("mw_exit_flush", FLUSH, 0, 0, 0, 0, 0);
    clear_inputs();
    dmem_ready = 1;
    cyc("run_ready_ign", NONE, 0, 0, 0, 0, 0);
    clear_inputs();

    // Redirect beats load-use
    EX_redirect = 1; ID_EX_memread = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_uses_rs1 = 1;
    cyc("redir_lu", FLUSH, 0, 0, 0, 0, 0);
    clear_inputs();
    dmem_req = 1; dmem_ready = 1;
    cyc("req_ready", NONE, 0, 0, 0, 0, 0);

    // Timeout into ERROR, sticky until reset
    dmem_ready = 0;
    cyc("to_run", FREEZE, 0, 0, 0, 0, 0);
    dmem_req = 0;
    for (int i = 0; i < 4; i++) cyc("to_wait", FREEZE, 0, 0, 0, 0, 0);
    dmem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      EX_redirect = i[0];
      cyc("err_sticky", FREEZE, 0, 0, 0, 0, 1);
    end
    EX_redirect = 0;
    reset = 1'b0;
    cyc("err_rst", FREEZE, 0, 0, 0, 0, 1);
    reset = 1'b1; dmem_ready = 0;
    cyc("after_rst", NONE, 0, 0, 0, 0, 0);

    // Reset in the middle of a wait
    dmem_req = 1;
    cyc("mw2_run", FREEZE, 0, 0, 0, 0, 0);
    cyc("mw2_wait", FREEZE, 0, 0, 0, 0, 0);
    reset = 1'b0; EX_redirect = 1;
    cyc("mw2_rst", NONE, 0, 0, 0, 0, 0);
    reset = 1'b1; dmem_req = 0; EX_redirect = 0;
    cyc("mw2_after", NONE, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
